uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmitter: the TX-direction companion to the `uart_receiver` block on the same link. It accepts bytes over a valid/ready handshake into a small FIFO. It then serialises each byte as an 8N1 frame on `tx`: start bit low, 8 data bits LSB first, stop bit high. Unlike the receiver, it runs from the system clock and divides down to the baud rate internally, so the host/PWM control logic can feed it directly.

## Interface
- `CLKS_PER_BIT`, 434: system clock cycles per UART bit (50 MHz / 115200); legal range ≥ 1.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, ≥ 2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_in`  input  8  byte to transmit.
- `data_valid`  input  1  `data_in` is valid this cycle.
- `data_ready`  output  1  FIFO can accept a byte; equals `!full` (combinational from FIFO count).
- `tx`  output  1  UART serial line; idles high.
- `busy`  output  1  high while a frame is on the line (state ≠ IDLE).

## Operation
- Push: a byte is written on any rising edge with `data_valid && data_ready`. When full, `data_valid` is ignored and no byte is written or lost from the FIFO.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, drive `tx`<=0 and go to START.
  - START: hold `tx`=0 for `CLKS_PER_BIT` cycles, then `tx`<=shift[0] and go to DATA with bit index 0.
  - DATA: hold each bit `CLKS_PER_BIT` cycles, LSB first. After bit 7 completes, `tx`<=1 and go to STOP.
  - STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. On the final cycle:
    - FIFO non-empty: pop, drive `tx`<=0, go to START. Back-to-back frames have no idle gap.
    - FIFO empty: go to IDLE.
- Baud counter: `$clog2(CLKS_PER_BIT)` bits minimum. Reloads to 0 on every bit boundary and counts 0..`CLKS_PER_BIT`-1; it never wraps mid-bit. Bit index is 3 bits, 0..7.
- FIFO: circular, with read/write pointers and a count.
  - Push and pop on the same edge are both honoured; count is unchanged.
  - A push while full is blocked by `data_ready`=0, even if a pop occurs on that edge. `data_ready` rises the cycle after the pop.
- `tx` is driven from a flop: glitch-free, with no combinational path from inputs.

## Timing
- Reset values (on the edge with `reset`=1):
  - `tx`=1, `busy`=0, state=IDLE, FIFO empty, `data_ready`=1.
  - Baud counter and bit index are 0.
- Reset mid-frame: the frame is aborted, `tx`=1 from the next edge, and the FIFO is flushed. `reset` overrides a simultaneous push.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM idle produces `tx`=0 and `busy`=1 from edge N+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles.
  - Bit k (k=0..7) occupies cycles (k+1)×`CLKS_PER_BIT` .. (k+2)×`CLKS_PER_BIT`-1 after the start edge.
  - Stop bit occupies 9×`CLKS_PER_BIT` .. 10×`CLKS_PER_BIT`-1.
- `busy` falls on the edge after the last stop-bit cycle, and only if the FIFO is empty.
- The FIFO pop happens on the same edge as the `tx` start-bit fall, so a full FIFO raises `data_ready` on that edge.
- `CLKS_PER_BIT`=1: one cycle per bit; the 10-cycle frame still holds.

## Test plan
- Single byte: `CLKS_PER_BIT`=4; push 0xA5 at edge N.
  - Required: `tx`=0 over cycles N+1..N+4.
  - Then data bits 1,0,1,0,0,1,0,1, each held 4 cycles.
  - Then `tx`=1 over 4 stop cycles; `busy` falls at N+41; frame is 40 cycles.
- Back-to-back: push 0x00 and 0xFF on consecutive edges.
  - Required: second start bit begins the cycle after the first stop bit ends.
  - `busy` stays high for 80 cycles and `tx` shows no idle gap.
- Backpressure: `FIFO_DEPTH`=4; hold `data_valid`=1 with bytes 0x01..0x06.
  - Required: first pop frees a slot, so 5 bytes are accepted (1 in shifter plus 4 in FIFO). `data_ready`=0 while full.
  - 0x06 is stalled until a pop, then accepted; all 6 frames are transmitted in order.
- Simultaneous push/pop: FIFO holding 2 bytes; push on the edge that pops for a new frame.
  - Required: count stays 2 and byte order is preserved.
- Reset mid-frame: assert `reset` during bit 3 of 0x3C with 2 bytes queued.
  - Required: `tx`=1, `busy`=0, `data_ready`=1 next edge; no further frames emitted.
- `CLKS_PER_BIT`=1: push 0x81.
  - Required: `tx` sequence 0,1,0,0,0,0,0,0,1,1, one bit per cycle.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter
//
// 8N1 UART transmitter with a small byte FIFO in front of it. Bytes are
// accepted over a valid/ready handshake and then sent as a start bit (low),
// eight data bits (LSB first) and a stop bit (high). The baud rate comes
// from dividing the system clock by CLKS_PER_BIT.
//
// Parameters:
//   CLKS_PER_BIT  system clock cycles per UART bit (>= 1)
//   FIFO_DEPTH    byte FIFO depth (power of two, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset; aborts any frame, flushes FIFO
//   data_in     byte to transmit
//   data_valid  data_in is valid this cycle
//   data_ready  FIFO can accept a byte (not full)
//   tx          serial line, idles high, driven from a flop
//   busy        a frame is on the line
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  // With a single cycle per bit the counter is still kept one bit wide so
  // the declarations stay legal; it simply never leaves 0.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // Serialiser state
  state_t           state_reg,    state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_idx_reg,  bit_idx_next;
  logic [7:0]       shift_reg,    shift_next;
  logic             tx_reg,       tx_next;
  logic             bit_done;

  assign fifo_empty = (count_reg == '0);
  assign data_ready = (count_reg != FIFO_FULL);
  // data_ready is the pre-edge view of the count, so a pop on the same edge
  // does not open a slot for a push until the following cycle.
  assign push       = data_valid && data_ready;
  assign bit_done   = (baud_cnt_reg == CNT_LAST);

  assign tx   = tx_reg;
  assign busy = (state_reg != IDLE);

  // ------------------------------------------------------------------
  // FIFO
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Serialiser FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

  // ------------------------------------------------------------------
  // Serialiser FSM: next state and outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = bit_done ? '0 : baud_cnt_reg + CNT_W'(1);
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    pop           = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        tx_next       = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          tx_next    = 1'b0;
          state_next = START;
        end
      end

      START: begin
        if (bit_done) begin
          tx_next      = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end

      DATA: begin
        if (bit_done) begin
          if (bit_idx_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_done) begin
          // Chain straight into the next frame when data is waiting so
          // back-to-back bytes leave no idle gap on the line.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//
// Drives two transmitters side by side, one at 4 clocks per bit and one at
// 1 clock per bit. A frame-level model (a byte list per device and a
// position within the current 10-bit frame) predicts tx, busy and
// data_ready every cycle. Directed scenarios add literal expectations on
// top of the model.
module tb_uart_transmitter;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       valid0, valid1;
  logic       rdy0, rdy1;
  logic       tx0, tx1;
  logic       busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  uart_transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (din),
    .data_valid (valid0),
    .data_ready (rdy0),
    .tx         (tx0),
    .busy       (busy0)
  );

  uart_transmitter #(.CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (din),
    .data_valid (valid1),
    .data_ready (rdy1),
    .tx         (tx1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ------------------------------------------------------------------
  // Frame-level model
  // ------------------------------------------------------------------
  logic [7:0] mfifo  [2][8];
  int         mcount [2];
  int         remain [2];   // samples left in current frame, 0 = idle
  logic [7:0] cur    [2];

  function automatic int cpb_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic exp_tx(input int i);
    int pos, slot;
    if (remain[i] == 0) return 1'b1;
    pos  = 10 * cpb_of(i) - remain[i];
    slot = pos / cpb_of(i);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur[i][slot - 1];
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      mcount[i] = 0;
      remain[i] = 0;
      cur[i]    = 8'h00;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          mcount[i] = 0;
          remain[i] = 0;
        end else begin
          logic rdy, vld;
          rdy = (mcount[i] < DEPTH);
          vld = (i == 0) ? valid0 : valid1;
          if (remain[i] > 0) remain[i]--;
          if (remain[i] == 0 && mcount[i] > 0) begin
            cur[i] = mfifo[i][0];
            for (int j = 0; j < 7; j++) mfifo[i][j] = mfifo[i][j + 1];
            mcount[i]--;
            remain[i] = 10 * cpb_of(i);
            $display("dut%0d frame start byte 0x%02h at %0t", i, cur[i], $time);
          end
          if (vld && rdy) begin
            mfifo[i][mcount[i]] = din;
            mcount[i]++;
          end
        end
      end
      @(negedge clk);
      chk("model_tx0",   int'(tx0),   int'(exp_tx(0)));
      chk("model_busy0", int'(busy0), int'(remain[0] != 0));
      chk("model_rdy0",  int'(rdy0),  int'(mcount[0] < DEPTH));
      chk("model_tx1",   int'(tx1),   int'(exp_tx(1)));
      chk("model_busy1", int'(busy1), int'(remain[1] != 0));
      chk("model_rdy1",  int'(rdy1),  int'(mcount[1] < DEPTH));
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  // Called just after a falling edge: presents inputs for the next rising
  // edge and returns at the following falling edge (post-edge view).
  task automatic cycle(input logic v0, input logic v1, input logic [7:0] b);
    valid0 = v0;
    valid1 = v1;
    din    = b;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 2000) begin
      cycle(1'b0, 1'b0, 8'h00);
      n++;
    end
    if (busy0 || busy1) fail_now("wait_idle");
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  logic seq_a5 [10];
  logic seq_81 [10];
  int   stall;
  logic accepted;
  logic done;

  initial begin
    seq_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    seq_81 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    reset  = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    din    = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_tx0",   int'(tx0),   1);
    chk("reset_busy0", int'(busy0), 0);
    chk("reset_rdy0",  int'(rdy0),  1);
    chk("reset_tx1",   int'(tx1),   1);
    chk("reset_busy1", int'(busy1), 0);
    chk("reset_rdy1",  int'(rdy1),  1);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 8'h00);

    // Single byte 0xA5 to both devices
    cycle(1'b1, 1'b1, 8'hA5);
    for (int k = 1; k <= 41; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (k <= 40) chk("a5_tx0", int'(tx0), int'(seq_a5[(k - 1) / 4]));
      if (k == 1 || k == 40 || k == 41) chk("a5_busy0", int'(busy0), int'(k <= 40));
      if (k <= 10) chk("a5_tx1", int'(tx1), int'(seq_a5[k - 1]));
      if (k == 10 || k == 11) chk("a5_busy1", int'(busy1), int'(k <= 10));
    end
    wait_idle();

    // 0x81 at one clock per bit
    cycle(1'b0, 1'b1, 8'h81);
    for (int k = 1; k <= 11; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (k <= 10) chk("x81_tx1", int'(tx1), int'(seq_81[k - 1]));
      else         chk("x81_busy1", int'(busy1), 0);
    end
    wait_idle();

    // Back-to-back 0x00 then 0xFF
    cycle(1'b1, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'hFF);
    for (int k = 2; k <= 81; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      chk("b2b_busy0", int'(busy0), int'(k <= 80));
      if (k == 40) chk("b2b_stop_tx0", int'(tx0), 1);
      if (k == 41) chk("b2b_start2_tx0", int'(tx0), 0);
      if (k == 45) chk("b2b_ff_bit0_tx0", int'(tx0), 1);
    end
    wait_idle();

    // Backpressure on dut0: bytes 0x01..0x06 with valid held
    stall = 0;
    for (int b = 1; b <= 6; b++) begin
      done = 1'b0;
      while (!done) begin
        accepted = rdy0;
        cycle(1'b1, 1'b0, 8'(b));
        if (accepted) begin
          done = 1'b1;
        end else begin
          stall++;
          if (stall > 200) begin
            fail_now("bp_stall_bound");
            done = 1'b1;
          end
        end
      end
      if (b == 5) chk("bp_full_after_5", int'(rdy0), 0);
    end
    chk("bp_stall_cycles", stall, 37);
    chk("bp_full_after_6", int'(rdy0), 0);
    wait_idle();

    // Push on the edge that pops with two bytes queued
    cycle(1'b1, 1'b0, 8'h11);
    cycle(1'b1, 1'b0, 8'h22);
    cycle(1'b1, 1'b0, 8'h33);
    repeat (38) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h44);
    chk("pp_start2_tx0", int'(tx0), 0);
    cycle(1'b1, 1'b0, 8'h55);
    chk("pp_rdy_at3", int'(rdy0), 1);
    cycle(1'b1, 1'b0, 8'h66);
    chk("pp_rdy_at4", int'(rdy0), 0);
    wait_idle();

    // Reset during bit 3 of 0x3C with two bytes queued
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b1, 1'b0, 8'hA1);
    cycle(1'b1, 1'b0, 8'hB2);
    repeat (15) cycle(1'b0, 1'b0, 8'h00);
    chk("rst_bit3_tx0", int'(tx0), 1);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 8'h77);
    reset = 1'b0;
    chk("rst_tx0",   int'(tx0),   1);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_rdy0",  int'(rdy0),  1);
    for (int k = 0; k < 50; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      chk("rst_quiet_tx0",   int'(tx0),   1);
      chk("rst_quiet_busy0", int'(busy0), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
